// File: rtl/fir_pkg.sv
// Shared types, default parameters and width helper for the multichannel FIR.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, SAVE} state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_COEF_W   = 16;
  localparam int DEF_TAPS     = 16;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_FRAC     = 15;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath with the output shift/saturate register stage.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int FRAC   = DEF_FRAC,
  parameter int CH_W   = 1
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     mac_en,
  input  logic                     save_en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  input  logic [CH_W-1:0]          chan,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic                     out_sat,
  output logic                     out_valid
);

  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + clog2_min1(TAPS);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PW-1:0]    prod_p0;
  logic signed [ACC_W-1:0] acc_p1;
  logic [DATA_W:0]         res_p1;

  // Returns {saturated, value}.
  function automatic logic [DATA_W:0] sat_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a >>> FRAC;
    if (r > SAT_MAX) return {1'b1, SAT_MAX[DATA_W-1:0]};
    if (r < SAT_MIN) return {1'b1, SAT_MIN[DATA_W-1:0]};
    return {1'b0, r[DATA_W-1:0]};
  endfunction

  assign prod_p0 = PW'(sample) * PW'(coef);
  assign res_p1  = sat_shift(acc_p1);

  // p0 -> p1: accumulate one product per MAC cycle
  always_ff @(posedge ck) begin
    if (rst) begin
      acc_p1    <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= save_en;
      if (clear) begin
        acc_p1 <= '0;
      end else if (mac_en) begin
        acc_p1 <= acc_p1 + ACC_W'(prod_p0);
      end
      // p1 -> output: shifted, saturated result held until the next SAVE
      if (save_en) begin
        out_sat  <= res_p1[DATA_W];
        out_data <= res_p1[DATA_W-1:0];
        out_chan <= chan;
      end
    end
  end

endmodule

// File: rtl/fir_multi.sv
// Time-multiplexed FIR: one shared coefficient set, one delay line per channel,
// one MAC per cycle; a new sample is taken only while the engine is idle.
module fir_multi
  import fir_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int TAPS     = DEF_TAPS,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int FRAC     = DEF_FRAC
) (
  input  logic                                 ck,
  input  logic                                 rst,
  input  logic signed [DATA_W-1:0]             in_data,
  input  logic [clog2_min1(CHANNELS)-1:0]      in_chan,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 coef_we,
  input  logic [clog2_min1(TAPS)-1:0]          coef_addr,
  input  logic signed [COEF_W-1:0]             coef_data,
  output logic signed [DATA_W-1:0]             out_data,
  output logic [clog2_min1(CHANNELS)-1:0]      out_chan,
  output logic                                 out_valid,
  output logic                                 out_sat
);

  localparam int CH_W = clog2_min1(CHANNELS);
  localparam int AW   = clog2_min1(TAPS);

  state_t                   state, state_nxt;
  logic [AW-1:0]            tap_p1;
  logic signed [DATA_W-1:0] sample_p0;
  logic [CH_W-1:0]          chan_p0;
  logic signed [DATA_W-1:0] line [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic                     chan_ok;
  logic                     take;
  logic                     last_tap;

  // Out-of-range tags complete the handshake but never start the engine.
  assign chan_ok  = 32'(in_chan) < 32'(CHANNELS);
  assign take     = in_valid && in_ready && chan_ok;
  assign last_tap = (tap_p1 == AW'(TAPS - 1));

  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (take) state_nxt = LOAD;
      end
      LOAD:    state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = SAVE;
      SAVE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: capture the sample at the handshake; p1: shift the line and walk the taps
  always_ff @(posedge ck) begin
    if (rst) begin
      tap_p1    <= '0;
      sample_p0 <= '0;
      chan_p0   <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++)
          line[c][t] <= '0;
      for (int t = 0; t < TAPS; t++)
        coef[t] <= '0;
    end else begin
      if (state == IDLE && coef_we) coef[coef_addr] <= coef_data;
      if (take) begin
        sample_p0 <= in_data;
        chan_p0   <= in_chan;
      end
      if (state == LOAD) begin
        tap_p1 <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          if (chan_p0 == CH_W'(c)) begin
            line[c][0] <= sample_p0;
            for (int t = 1; t < TAPS; t++)
              line[c][t] <= line[c][t-1];
          end
        end
      end else if (state == MAC) begin
        tap_p1 <= tap_p1 + AW'(1);
      end
    end
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .FRAC   (FRAC),
    .CH_W   (CH_W)
  ) u_mac (
    .ck        (ck),
    .rst       (rst),
    .clear     (state == LOAD),
    .mac_en    (state == MAC),
    .save_en   (state == SAVE),
    .sample    (line[chan_p0][tap_p1]),
    .coef      (coef[tap_p1]),
    .chan      (chan_p0),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_sat   (out_sat),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_fir_multi.sv
// Randomized and directed bench for fir_multi against a sum-of-products reference model.
module tb_fir_multi;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 16;
  localparam int CHN  = 3;
  localparam int FRAC = 15;
  localparam int LAT  = TAPS + 2;
  localparam int PER  = TAPS + 3;
  localparam int OMAX = (1 <<< (DW - 1)) - 1;
  localparam int OMIN = -(1 <<< (DW - 1));

  logic                 ck = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] in_data;
  logic [1:0]           in_chan;
  logic                 in_valid;
  logic                 in_ready;
  logic                 coef_we;
  logic [3:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic signed [DW-1:0] out_data;
  logic [1:0]           out_chan;
  logic                 out_valid;
  logic                 out_sat;

  always #5 ck = ~ck;

  fir_multi #(
    .DATA_W   (DW),
    .COEF_W   (CW),
    .TAPS     (TAPS),
    .CHANNELS (CHN),
    .FRAC     (FRAC)
  ) dut (
    .ck        (ck),
    .rst       (rst),
    .in_data   (in_data),
    .in_chan   (in_chan),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_sat   (out_sat)
  );

  typedef struct {
    int due;
    int data;
    int chan;
    bit sat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   hist [CHN][TAPS];
  int   cmod [TAPS];
  exp_t pend [$];
  int   edge_n = 0;
  int   next_free = 0;
  bit   started = 1'b0;
  int   h_data = 0;
  int   h_chan = 0;
  bit   h_sat = 1'b0;
  int   acc_edges [$];
  int   ch0_outs [$];
  int   ch1_outs [$];
  int   n_out = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
    end
  endtask

  function automatic exp_t predict(input int ch, input int due);
    longint acc;
    longint r;
    exp_t   e;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(hist[ch][k]) * longint'(cmod[k]);
    r = acc >>> FRAC;
    e.due  = due;
    e.chan = ch;
    e.sat  = 1'b0;
    if (r > OMAX) begin
      e.data = OMAX; e.sat = 1'b1;
    end else if (r < OMIN) begin
      e.data = OMIN; e.sat = 1'b1;
    end else begin
      e.data = int'(r);
    end
    return e;
  endfunction

  // Reference model, advanced on every rising edge from the signals the DUT sees.
  initial begin
    bit idle;
    int ch;
    forever begin
      @(posedge ck);
      edge_n++;
      if (rst) begin
        started = 1'b1;
        for (int c = 0; c < CHN; c++)
          for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
        for (int k = 0; k < TAPS; k++) cmod[k] = 0;
        pend.delete();
        h_data = 0; h_chan = 0; h_sat = 1'b0;
        next_free = edge_n + 1;
      end else if (started) begin
        idle = (edge_n >= next_free);
        if (idle && coef_we) cmod[coef_addr] = int'(coef_data);
        if (idle && in_valid) begin
          if (in_chan < CHN) begin
            ch = int'(in_chan);
            for (int k = TAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = int'(in_data);
            pend.push_back(predict(ch, edge_n + LAT));
            next_free = edge_n + PER;
          end else begin
            next_free = edge_n + 1;
          end
        end
        if (in_valid && in_ready && in_chan < CHN) acc_edges.push_back(edge_n);
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  initial begin
    bit ev;
    exp_t e;
    forever begin
      @(negedge ck);
      if (started) begin
        ev = 1'b0;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
          e = pend.pop_front();
          ev = 1'b1;
          h_data = e.data; h_chan = e.chan; h_sat = e.sat;
        end
        check("in_ready", in_ready, (edge_n + 1 >= next_free));
        check("out_valid", out_valid, ev);
        check("out_data", out_data, h_data);
        check("out_chan", out_chan, h_chan);
        check("out_sat", out_sat, h_sat);
        if (out_valid) begin
          n_out++;
          if (out_chan == 2'd0) ch0_outs.push_back(int'(out_data));
          if (out_chan == 2'd1) ch1_outs.push_back(int'(out_data));
        end
      end
    end
  end

  task automatic send(input int d, input int ch, input bit we, input int wa, input int wd);
    int n;
    n = 0;
    @(negedge ck);
    in_valid = 1'b1; in_data = DW'(d); in_chan = 2'(ch);
    coef_we = we; coef_addr = 4'(wa); coef_data = CW'(wd);
    while (!in_ready && n < 200) begin
      @(negedge ck);
      n++;
    end
    if (n >= 200) check("send_timeout", n, 0);
    @(negedge ck);
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic write_coef(input int a, input int d);
    int n;
    n = 0;
    @(negedge ck);
    coef_we = 1'b1; coef_addr = 4'(a); coef_data = CW'(d);
    while (!in_ready && n < 200) begin
      @(negedge ck);
      n++;
    end
    if (n >= 200) check("coef_timeout", n, 0);
    @(negedge ck);
    coef_we = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge ck);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, n, sum;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_chan = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    idle_cycles(3);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Impulse through tap 3 at half gain.
    write_coef(3, 16384);
    ch0_outs.delete();
    send(1000, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) send(0, 0, 0, 0, 0);
    idle_cycles(LAT + 2);
    check("imp_count", ch0_outs.size(), 6);
    sum = 0;
    foreach (ch0_outs[i]) if (i != 3) sum += (ch0_outs[i] < 0) ? -ch0_outs[i] : ch0_outs[i];
    check("imp_out3", ch0_outs[3], 500);
    check("imp_others", sum, 0);

    // Channel isolation: ch0 impulse interleaved with ch1 zeros.
    ch0_outs.delete(); ch1_outs.delete();
    for (int i = 0; i < 4; i++) begin
      send((i == 0) ? 1000 : 0, 0, 0, 0, 0);
      send(0, 1, 0, 0, 0);
    end
    idle_cycles(LAT + 2);
    sum = 0;
    foreach (ch1_outs[i]) sum += (ch1_outs[i] < 0) ? -ch1_outs[i] : ch1_outs[i];
    check("iso_ch1_count", ch1_outs.size(), 4);
    check("iso_ch1_zero", sum, 0);
    check("iso_ch0_out3", ch0_outs[3], 500);

    // Saturation at both rails.
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int i = 0; i < TAPS; i++) send(32767, 0, 0, 0, 0);
    idle_cycles(LAT + 2);
    check("satp_data", out_data, 32767);
    check("satp_flag", out_sat, 1);
    for (int i = 0; i < TAPS; i++) send(-32768, 0, 0, 0, 0);
    idle_cycles(LAT + 2);
    check("satn_data", out_data, -32768);
    check("satn_flag", out_sat, 1);

    // in_valid held high: accepts must be exactly PER edges apart.
    acc_edges.delete();
    n = 0;
    @(negedge ck);
    in_valid = 1'b1; in_chan = 2'd0; in_data = DW'($urandom);
    while (acc_edges.size() < 4 && n < 200) begin
      @(negedge ck);
      in_data = DW'($urandom);
      n++;
    end
    in_valid = 1'b0;
    check("bp_accepts", acc_edges.size(), 4);
    for (int i = 1; i < acc_edges.size(); i++)
      check("bp_spacing", acc_edges[i] - acc_edges[i-1], PER);
    idle_cycles(LAT + 2);

    // Reset on the 8th MAC cycle aborts the operation.
    snap = n_out;
    send(12345, 0, 0, 0, 0);
    idle_cycles(8);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    idle_cycles(LAT + 4);
    check("rstmac_no_out", n_out, snap);
    check("rstmac_data", out_data, 0);
    check("rstmac_sat", out_sat, 0);
    send(1234, 0, 0, 0, 0);
    idle_cycles(LAT + 2);
    check("rstmac_next_count", n_out, snap + 1);
    check("rstmac_next_data", out_data, 0);

    // Illegal tag, then a ch0 sample with a coincident coefficient write.
    snap = n_out;
    send(5000, 3, 0, 0, 0);
    idle_cycles(LAT + 2);
    check("illegal_no_out", n_out, snap);
    send(2000, 0, 1, 0, 16384);
    idle_cycles(LAT + 2);
    check("illegal_after_data", out_data, 1000);
    check("illegal_after_chan", out_chan, 0);

    // Randomized traffic, including illegal tags and writes during busy periods.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        write_coef(int'($urandom_range(0, TAPS - 1)),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4000)) - 2000
                                               : int'($urandom_range(0, 65535)) - 32768);
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, TAPS - 1)),
           int'($urandom_range(0, 4000)) - 2000);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(0, 25)));
    end
    idle_cycles(LAT + 4);
    check("drain_pending", pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_multi.md
FIR_MULTI -- requirements
Module: fir_multi

Interface
REQ-001 Parameter DATA_W, default 16, signed sample width of in_data and out_data.
REQ-002 Parameter COEF_W, default 16, signed coefficient width.
REQ-003 Parameter TAPS, default 16, filter length; power of two, range 2..64.
REQ-004 Parameter CHANNELS, default 2, independent delay lines sharing one coefficient set; range 1..8.
REQ-005 Parameter FRAC, default 15, coefficient fractional bits; result is the accumulator shifted right arithmetically by FRAC.
REQ-006 ck  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 in_data  input  DATA_W  signed input sample.
REQ-009 in_chan  input  clog2(CHANNELS) (min 1)  channel tag of in_data.
REQ-010 in_valid  input  1  sample offered.
REQ-011 in_ready  output  1  block can accept; sample taken when in_valid and in_ready are both high.
REQ-012 coef_we  input  1  coefficient write strobe.
REQ-013 coef_addr  input  clog2(TAPS)  coefficient index.
REQ-014 coef_data  input  COEF_W  signed coefficient value.
REQ-015 out_data  output  DATA_W  signed filtered sample, registered.
REQ-016 out_chan  output  clog2(CHANNELS) (min 1)  channel tag of out_data.
REQ-017 out_valid  output  1  single-cycle pulse; out_data, out_chan and out_sat are valid while it is high.
REQ-018 out_sat  output  1  the result in out_data was saturated.

Function
REQ-019 FSM states and transitions:
  - IDLE -> LOAD on handshake.
  - LOAD -> MAC after one cycle.
  - MAC -> SAVE when tap index = TAPS-1.
  - SAVE -> IDLE after one cycle.
REQ-020 in_ready shall be high only in IDLE; coef_we shall be honoured only in IDLE and ignored in all other states.
REQ-021 LOAD: shift the selected channel's delay line by one (tap0 <= in_data), clear the accumulator, and zero the tap index; other channels' lines are unchanged.
REQ-022 MAC: one product per cycle, acc += line[chan][k] * coef[k], for k = 0..TAPS-1 with k incrementing each cycle.
REQ-023 The accumulator shall be DATA_W+COEF_W+clog2(TAPS) bits signed and shall never overflow.
REQ-024 SAVE: r = acc >>> FRAC, then:
  - r > 2^(DATA_W-1)-1 -> out_data = max, out_sat = 1.
  - r < -2^(DATA_W-1) -> out_data = min, out_sat = 1.
  - otherwise out_data = r[DATA_W-1:0], out_sat = 0.
REQ-025 out_valid shall rise exactly TAPS+2 cycles after the accepting edge.
REQ-026 Sample throughput shall be one sample per TAPS+3 cycles; there is no output backpressure.
REQ-027 out_data, out_chan and out_sat shall hold their values until the next SAVE.
REQ-028 Handshake with in_chan >= CHANNELS: the handshake completes, the sample is discarded, the FSM stays in IDLE, and no output is produced.
REQ-029 coef_we in IDLE coincident with a handshake: the coefficient write shall take effect before the MAC phase that follows.

Reset
REQ-030 rst high at any edge, including mid-MAC, shall set:
  - FSM to IDLE; tap index, accumulator and all delay lines to 0.
  - out_data, out_chan and out_sat to 0; out_valid to 0.
  - all coefficients to 0.
  - in_ready high on the first edge after rst is released.
REQ-031 An operation aborted by reset shall produce no out_valid.

Structure
REQ-032 Package fir_pkg shall hold the FSM state enum (IDLE, LOAD, MAC, SAVE), the default parameter constants, and a clog2-safe width helper.
REQ-033 Sub-module fir_mac shall hold the accumulator, the multiply and the SAVE shift/saturate logic; fir_multi shall hold the FSM, delay lines, coefficient store and handshake.

Verification
REQ-034 Impulse: coef[3] = 16384, all other coefficients 0; ch0 sample 1000, then 0s -> 4th ch0 output = 500, all other outputs = 0.
REQ-035 Saturation: all coefficients 32767; 16 ch0 samples of 32767 -> final out_data = 32767, out_sat = 1; repeat with -32768 samples -> final out_data = -32768, out_sat = 1.
REQ-036 Channel isolation: impulse 1000 on ch0 interleaved with 0s on ch1 -> every ch1 output = 0, out_chan matches the input tag.
REQ-037 Backpressure: in_valid held high continuously -> in_ready low for TAPS+2 cycles after each accept, and accepts spaced exactly TAPS+3 cycles apart.
REQ-038 Reset mid-MAC: rst asserted at cycle 8 of MAC -> no out_valid, all outputs 0, and the next sample result computed from zeroed lines and coefficients = 0.
REQ-039 Illegal channel: CHANNELS = 3, in_chan = 3 -> handshake completes, no out_valid, and subsequent ch0 results are unaffected.
